// File: rtl/round_robin_mux_arbiter_if.sv
// round_robin_mux_arbiter_if: request, one-hot grant and mux-select bundle
interface round_robin_mux_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic address0;
  logic address1;
  logic sel_valid;
  modport master (input req, output gnt, address0, address1, sel_valid);
  modport slave (output req, input gnt, address0, address1, sel_valid);
endinterface

// File: rtl/round_robin_mux_arbiter.sv
// round_robin_mux_arbiter: round-robin owner of a 4:1 mux with hold limit and turnaround gap
module round_robin_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  round_robin_mux_arbiter_if.master bus
);
  localparam int unsigned HW = MAX_HOLD > 2 ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned GW = GAP_CYCLES > 2 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, own_q, own_d, who;
  logic [3:0] gnt_q, gnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0] win, win_rel;
  logic limit, rel, take;
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    pick = '0;
    for (int k = 3; k >= 0; k--)
      if (r[p + 2'(k)]) pick = {1'b1, p + 2'(k)};
  endfunction
  assign win = pick(bus.req, ptr_q);
  assign win_rel = pick(bus.req & ~gnt_q, own_q + 2'd1);
  assign limit = MAX_HOLD != 0 && hold_q == HOLD_LAST && |(bus.req & ~gnt_q);
  assign rel = !bus.req[own_q] || limit;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    gnt_d = gnt_q;
    hold_d = hold_q;
    gap_d = gap_q;
    take = 1'b0;
    who = win[1:0];
    case (state_q)
      IDLE: take = win[2];
      GRANT: begin
        if (rel) begin
          gnt_d = '0;
          ptr_d = own_q + 2'd1;
          gap_d = '0;
          state_d = GAP_CYCLES != 0 ? GAP : IDLE;
          take = GAP_CYCLES == 0 && win_rel[2];
          who = win_rel[1:0];
        end else begin
          hold_d = (MAX_HOLD == 0 || hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
        end
      end
      default: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          take = win[2];
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
    if (take) begin
      state_d = GRANT;
      own_d = who;
      gnt_d = 4'b1 << who;
      hold_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      gnt_q <= '0;
      hold_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      gnt_q <= gnt_d;
      hold_q <= hold_d;
      gap_q <= gap_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.address0 = own_q[0];
  assign bus.address1 = own_q[1];
  assign bus.sel_valid = |gnt_q;
endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// tb_round_robin_mux_arbiter: scoreboard bench against a cycle-level arbitration model
module tb_round_robin_mux_arbiter;
  localparam int MAX_HOLD = 8;
  localparam int GAP = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  int own = -1;
  int addr = 0;
  int ptr = 0;
  int held = 0;
  int gap = 0;
  round_robin_mux_arbiter_if bus();
  round_robin_mux_arbiter #(.MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic int arb(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  always @(posedge clk) begin
    logic [3:0] r;
    logic [3:0] others;
    logic [3:0] eg;
    int w;
    r = bus.req;
    w = -1;
    if (reset) begin
      own = -1;
      addr = 0;
      ptr = 0;
      held = 0;
      gap = 0;
    end else if (own >= 0) begin
      others = r & ~(4'b1 << own);
      if (!r[own] || (MAX_HOLD != 0 && held >= MAX_HOLD - 1 && others != 0)) begin
        ptr = (own + 1) % 4;
        own = -1;
        if (GAP > 0) gap = GAP;
        else w = arb(others, ptr);
      end else begin
        held++;
      end
    end else if (gap > 0) begin
      gap--;
      if (gap == 0) w = arb(r, ptr);
    end else begin
      w = arb(r, ptr);
    end
    if (w >= 0) begin
      own = w;
      addr = w;
      held = 0;
    end
    eg = own >= 0 ? 4'(1 << own) : 4'b0;
    exp_q.push_back({eg, 2'(addr), own >= 0});
  end
  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (reset) e = '0;
      a = {bus.gnt, bus.address1, bus.address0, bus.sel_valid};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t req=%b: got gnt=%b addr=%b%b sel_valid=%b, expected gnt=%b addr=%b%b sel_valid=%b",
                 $time, bus.req, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
      end
    end
  end
  task automatic check_reset();
    checks++;
    if ({bus.gnt, bus.address1, bus.address0, bus.sel_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset state @%0t: gnt=%b addr=%b%b sel_valid=%b", $time, bus.gnt, bus.address1, bus.address0, bus.sel_valid);
    end
  endtask
  task automatic drive(input logic [3:0] r, input int n);
    bus.req = r;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout @%0t: stimulus did not complete", $time);
    $finish;
  end
  initial begin
    bus.req = 4'b1111;
    #1 check_reset();
    repeat (3) @(posedge clk);
    #1 check_reset();
    reset = 1'b0;
    drive(4'b0000, 2);
    drive(4'b0100, 6);
    drive(4'b0000, 3);
    drive(4'b1111, 45);
    drive(4'b0000, 3);
    drive(4'b0101, 3);
    drive(4'b0100, 6);
    drive(4'b0000, 3);
    drive(4'b1000, 20);
    drive(4'b0000, 3);
    drive(4'b0100, 4);
    #2 reset = 1'b1;
    bus.req = 4'b0011;
    #1 check_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drive(4'b0011, 5);
    drive(4'b0000, 2);
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      @(posedge clk);
      #1;
    end
    drive(4'b0000, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
